trojan_response_checker: RTL and testbench

//  Consumer end of the exhaustive-vector test flow: samples each applied input vector and the DUT's

---
 rtl/trojan_response_checker.sv | 126 ++++++++++++
 tb/tb_trojan_response_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trojan_response_checker.sv
// trojan_response_checker
// Consumer end of an exhaustive-vector test flow. Each run is exactly
// 2**NUM_IN vectors presented in ascending order. For every accepted
// vector the DUT's single-bit response is compared against the golden
// truth table. The block accumulates the mismatch count, captures the
// first failing vector and flags any out-of-order vector. At the end of
// the run it reports pass/fail.
//
// Handshake: vec_valid qualifies vec_in/resp_in for one cycle. There is no
// ready signal. The block accepts every valid beat while it is in RUN and
// ignores vec_valid in IDLE and DONE. A beat is consumed on the rising CK
// edge where vec_valid is high, and its effect shows on the outputs after
// that edge.

module trojan_response_checker #(
  parameter int                       NUM_IN = 5,
  parameter logic [(2**NUM_IN)-1:0]   GOLDEN = '0
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              vec_valid,
  input  logic [NUM_IN-1:0] vec_in,
  input  logic              resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   mism_count,
  output logic [NUM_IN-1:0] first_fail_vec,
  output logic              first_fail_vld,
  output logic              seq_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index of the last vector in a run; reaching it ends the run.
  localparam logic [NUM_IN-1:0] LAST_IDX = '1;
  localparam logic [NUM_IN-1:0] IDX_ONE  = {{(NUM_IN-1){1'b0}}, 1'b1};

  state_t              state;
  logic [NUM_IN-1:0]   exp_idx;

  // Per-beat evaluation of the current input
  logic                golden_bit;
  logic                mismatch;
  logic                order_err;
  logic                last_vec;
  logic [NUM_IN:0]     mism_next;
  logic                seq_next;

  // Compare the current beat against the truth table and the expected order.
  // The lookup uses the vector that was actually applied, not exp_idx.
  always_comb begin
    golden_bit = GOLDEN[vec_in];
    mismatch   = (resp_in != golden_bit);
    order_err  = (vec_in != exp_idx);
    last_vec   = (exp_idx == LAST_IDX);
    mism_next  = mism_count + {{NUM_IN{1'b0}}, mismatch};
    seq_next   = seq_err | order_err;
  end

  // Run control FSM with all results and status flags registered.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      exp_idx        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mism_count     <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
      seq_err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Results stay frozen until a new run starts. vec_valid is ignored.
          if (start) begin
            state          <= ST_RUN;
            exp_idx        <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mism_count     <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
            seq_err        <= 1'b0;
          end
        end
        ST_RUN: begin
          // start is ignored here. Gaps without vec_valid hold all state.
          if (vec_valid) begin
            mism_count <= mism_next;
            seq_err    <= seq_next;
            if (mismatch && !first_fail_vld) begin
              first_fail_vec <= vec_in;
              first_fail_vld <= 1'b1;
            end
            if (last_vec) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mism_next == '0) && !seq_next;
            end else begin
              exp_idx <= exp_idx + IDX_ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_trojan_response_checker.sv
// Bench for trojan_response_checker. It runs directed runs T1..T6 plus
// randomized runs. A behavioural model checks the DUT every cycle. The model
// keeps the accepted (vector, response) pairs of the current run in queues
// and derives every result from that list.
module tb_trojan_response_checker;

  localparam int          NUM_IN = 5;
  localparam int          NV     = 32;
  localparam logic [31:0] GOLD   = 32'hA5A5_0F0F;

  logic              CK;
  logic              reset;
  logic              start;
  logic              vec_valid;
  logic [NUM_IN-1:0] vec_in;
  logic              resp_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [NUM_IN:0]   mism_count;
  logic [NUM_IN-1:0] first_fail_vec;
  logic              first_fail_vld;
  logic              seq_err;
  logic [1:0]        state_dbg;

  trojan_response_checker #(.NUM_IN(NUM_IN), .GOLDEN(GOLD)) dut (
    .CK(CK), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_in(vec_in), .resp_in(resp_in), .busy(busy), .done(done),
    .pass(pass), .mism_count(mism_count), .first_fail_vec(first_fail_vec),
    .first_fail_vld(first_fail_vld), .seq_err(seq_err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial CK = 1'b0;
  always #5 CK = ~CK;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;
  // Packed final results: {pass, mism_count[5:0], first_fail_vld, first_fail_vec[4:0], seq_err}
  logic [13:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [13:0] pack_lit(input bit p, input int m, input bit v,
                                           input int fv, input bit s);
    logic [5:0] m6;
    logic [4:0] f5;
    m6 = 6'(m);
    f5 = 5'(fv);
    return {p, m6, v, f5, s};
  endfunction

  // ---------------- behavioural model ----------------
  int q_vec[$];
  bit q_resp[$];
  bit m_busy = 0;
  bit m_done = 0;

  always @(posedge CK or posedge reset) begin
    if (reset) begin
      q_vec.delete(); q_resp.delete();
      m_busy = 0; m_done = 0;
    end else if (!m_busy && start) begin
      q_vec.delete(); q_resp.delete();
      m_busy = 1; m_done = 0;
    end else if (m_busy && vec_valid) begin
      q_vec.push_back(int'(vec_in));
      q_resp.push_back(resp_in);
      if (q_vec.size() == NV) begin
        m_busy = 0; m_done = 1;
      end
    end
  end

  function automatic int m_mism();
    int n = 0;
    foreach (q_vec[i]) if (q_resp[i] != GOLD[q_vec[i]]) n++;
    return n;
  endfunction

  function automatic int m_first();
    foreach (q_vec[i]) if (q_resp[i] != GOLD[q_vec[i]]) return i;
    return -1;
  endfunction

  function automatic bit m_seq();
    foreach (q_vec[i]) if (q_vec[i] != i) return 1;
    return 0;
  endfunction

  // Every-cycle comparison of the DUT against the model
  always @(negedge CK) begin
    if (cmp_en) begin
      int ff;
      ff = m_first();
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("pass", pass, m_done && m_mism() == 0 && !m_seq());
      chk("mism_count", mism_count, m_mism());
      chk("first_fail_vld", first_fail_vld, ff >= 0);
      chk("first_fail_vec", first_fail_vec, (ff >= 0) ? q_vec[ff] : 0);
      chk("seq_err", seq_err, m_seq());
      chk("state_idle", state_dbg == 2'd0, !m_busy && !m_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(posedge CK); #1;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec_in    = 5'($urandom_range(0, NV-1));
    resp_in   = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int v, input bit r, input bit s);
    @(posedge CK); #1;
    start     = s;
    vec_valid = 1'b1;
    vec_in    = 5'(v);
    resp_in   = r;
  endtask

  // One run: start pulse, then 32 vectors (optionally with two positions
  // swapped), responses inverted where flip[v]=1, and random gaps.
  // stop_at >= 0 abandons the run after that many vectors.
  task automatic run(input logic [31:0] flip, input int sa, input int sb,
                     input int max_gap, input bit noisy, input int stop_at);
    int order[NV];
    int tmp;
    for (int i = 0; i < NV; i++) order[i] = i;
    if (sa >= 0) begin
      tmp = order[sa]; order[sa] = order[sb]; order[sb] = tmp;
    end
    @(posedge CK); #1;
    start = 1'b1; vec_valid = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i == stop_at) return;
      for (int g = $urandom_range(0, max_gap); g > 0; g--) idle_cycle();
      send(order[i], GOLD[order[i]] ^ flip[order[i]],
           noisy ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    // Last vector is on the inputs but not yet sampled
    chk("busy_before_last", busy, 1);
    @(posedge CK); #1;
    start = 1'b0; vec_valid = 1'b0;
    chk("busy_after_last", busy, 0);
    chk("done_after_last", done, 1);
    // In DONE, vec_valid must be ignored
    for (int k = 0; k < 2; k++) begin
      @(posedge CK); #1;
      vec_valid = 1'($urandom_range(0, 1));
      vec_in    = 5'($urandom_range(0, NV-1));
      resp_in   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_result(input string name);
    logic [13:0] req;
    @(negedge CK);
    req = exp_q.pop_front();
    chk(name, {pass, mism_count, first_fail_vld, first_fail_vec, seq_err}, req);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {busy, done, pass, mism_count, first_fail_vld, first_fail_vec, seq_err}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] flip;
    int sa;
    reset = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_in = '0; resp_in = 1'b0;
    #2 reset = 1'b1;
    cmp_en = 1;
    repeat (2) @(posedge CK);
    #1;
    check_all_zero("reset_state");
    reset = 1'b0;
    idle_cycle();
    // vec_valid in IDLE is ignored
    send(3, 1'b1, 1'b0);
    idle_cycle();

    // T1: clean run
    exp_q.push_back(pack_lit(1, 0, 0, 0, 0));
    run(32'h0, -1, -1, 0, 0, -1);
    check_result("t1_clean");

    // T2: responses inverted at v=5 and v=20
    exp_q.push_back(pack_lit(0, 2, 1, 5, 0));
    run(32'h0010_0020, -1, -1, 0, 0, -1);
    check_result("t2_two_mism");

    // T3: every response inverted
    exp_q.push_back(pack_lit(0, 32, 1, 0, 0));
    run(32'hFFFF_FFFF, -1, -1, 0, 0, -1);
    check_result("t3_all_mism");

    // T4: vectors 7 and 8 swapped, responses correct
    exp_q.push_back(pack_lit(0, 0, 0, 0, 1));
    run(32'h0, 7, 8, 0, 0, -1);
    check_result("t4_seq_err");

    // T5: random gaps of 0..3 idle cycles, plus start pulses during the run
    exp_q.push_back(pack_lit(1, 0, 0, 0, 0));
    run(32'h0, -1, -1, 3, 1, -1);
    check_result("t5_gaps");

    // T6: reset in the middle of a T2-style run, then a clean run
    run(32'h0010_0020, -1, -1, 1, 0, 12);
    @(posedge CK); #1;
    chk("t6_mism_before_reset", mism_count, 1);
    vec_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset_mid_run");
    @(posedge CK); #1;
    reset = 1'b0;
    idle_cycle();
    exp_q.push_back(pack_lit(1, 0, 0, 0, 0));
    run(32'h0, -1, -1, 0, 0, -1);
    check_result("t6_rerun");

    // Randomized runs, checked by the every-cycle model
    for (int r = 0; r < 8; r++) begin
      flip = $urandom() & $urandom() & $urandom();
      sa   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NV-2) : -1;
      run(flip, sa, sa + 1, 3, 1, -1);
    end

    repeat (3) idle_cycle();
    chk("exp_q_drained", exp_q.size(), 0);
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
